branch_predictor: RTL and testbench

Dynamic branch predictor and redirect generator, the prediction-side counterpart of the execute-stage branch comparator. Fetch sends a PC and one cycle later receives a predicted next PC from a direct-mapped table of 2-bit saturating counters and targets. Execute feeds back each resolved conditional branch: the comparator's taken/not-taken, the computed target, and the prediction that fetch used. The block trains its table from this feedback, raises a registered redirect on every misprediction, and counts mispredictions.

---
 rtl/branch_predictor.sv | 115 +++++++++++
 tb/tb_branch_predictor.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped 2-bit branch predictor with redirect generation
// Table is trained from resolved branches; mispredictions raise a registered redirect.
module branch_predictor #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_req,
  input  logic [31:0]      pred_pc,
  output logic             pred_resp_valid,
  output logic             pred_take,
  output logic [31:0]      pred_next_pc,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_take,
  input  logic [31:0]      upd_pred_next_pc,
  input  logic             flush_tbl,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  logic             tbl_valid  [ENTRIES];
  logic [TAG_W-1:0] tbl_tag    [ENTRIES];
  logic [1:0]       tbl_ctr    [ENTRIES];
  logic [31:0]      tbl_target [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic             lk_hit;
  logic             lk_take;
  logic [31:0]      lk_next;
  logic             up_hit;
  logic             mispredict;
  logic [31:0]      actual_next;

  // Lookup reads the table as it stands before this cycle's training or flush.
  always_comb begin
    lk_idx      = pred_pc[IDX_W+1:2];
    lk_hit      = tbl_valid[lk_idx] && (tbl_tag[lk_idx] == pred_pc[31:IDX_W+2]);
    lk_take     = lk_hit && tbl_ctr[lk_idx][1];
    lk_next     = lk_take ? tbl_target[lk_idx] : pred_pc + 32'd4;
    up_idx      = upd_pc[IDX_W+1:2];
    up_hit      = tbl_valid[up_idx] && (tbl_tag[up_idx] == upd_pc[31:IDX_W+2]);
    actual_next = upd_taken ? upd_target : upd_pc + 32'd4;
    mispredict  = (upd_pred_take != upd_taken) ||
                  (upd_taken && (upd_pred_next_pc != upd_target));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_resp_valid <= 1'b0;
      pred_take       <= 1'b0;
      pred_next_pc    <= 32'd0;
    end else begin
      pred_resp_valid <= pred_req;
      if (pred_req) begin
        pred_take    <= lk_take;
        pred_next_pc <= lk_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid   <= 1'b0;
      redirect_pc      <= 32'd0;
      mispredict_count <= '0;
    end else begin
      redirect_valid <= upd_valid && mispredict;
      if (upd_valid && mispredict) begin
        redirect_pc <= actual_next;
        if (mispredict_count != {CNT_W{1'b1}})
          mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

  // A flush in the same cycle as an update discards that update's training.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_tag[i]    <= '0;
        tbl_ctr[i]    <= 2'b01;
        tbl_target[i] <= 32'd0;
      end
    end else if (flush_tbl) begin
      for (int i = 0; i < ENTRIES; i++)
        tbl_valid[i] <= 1'b0;
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          tbl_target[up_idx] <= upd_target;
          if (tbl_ctr[up_idx] != 2'b11)
            tbl_ctr[up_idx] <= tbl_ctr[up_idx] + 2'd1;
        end else if (tbl_ctr[up_idx] != 2'b00) begin
          tbl_ctr[up_idx] <= tbl_ctr[up_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        tbl_valid[up_idx]  <= 1'b1;
        tbl_tag[up_idx]    <= upd_pc[31:IDX_W+2];
        tbl_target[up_idx] <= upd_target;
        tbl_ctr[up_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor
// Reference table model predicts every response; each task compares as outputs appear.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pred_req = 1'b0;
  logic [31:0] pred_pc = 32'd0;
  logic        pred_resp_valid;
  logic        pred_take;
  logic [31:0] pred_next_pc;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'd0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = 32'd0;
  logic        upd_pred_take = 1'b0;
  logic [31:0] upd_pred_next_pc = 32'd0;
  logic        flush_tbl = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [3:0]  mispredict_count;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .pred_req(pred_req), .pred_pc(pred_pc),
    .pred_resp_valid(pred_resp_valid), .pred_take(pred_take), .pred_next_pc(pred_next_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_take(upd_pred_take), .upd_pred_next_pc(upd_pred_next_pc),
    .flush_tbl(flush_tbl),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mispredict_count(mispredict_count)
  );

  typedef struct packed {
    logic        pr;
    logic [31:0] ppc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] upnpc;
    logic        fl;
  } stim_t;

  // reference model state
  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  logic [1:0]  m_ctr   [16];
  logic [31:0] m_tgt   [16];
  logic        m_take;
  logic [31:0] m_next;
  logic [31:0] m_rpc;
  logic [3:0]  m_cnt;

  logic [33:0] pred_q [$];
  logic [36:0] red_q  [$];

  function automatic stim_t lk(input logic [31:0] pc);
    stim_t s = '0;
    s.pr = 1'b1; s.ppc = pc;
    return s;
  endfunction

  function automatic stim_t up(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                               input logic pt, input logic [31:0] pnpc);
    stim_t s = '0;
    s.uv = 1'b1; s.upc = pc; s.ut = t; s.utgt = tgt; s.upt = pt; s.upnpc = pnpc;
    return s;
  endfunction

  function automatic stim_t fl();
    stim_t s = '0;
    s.fl = 1'b1;
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      m_valid[k] = 1'b0; m_ctr[k] = 2'b01; m_tag[k] = '0; m_tgt[k] = '0;
    end
    m_take = 1'b0; m_next = 32'd0; m_rpc = 32'd0; m_cnt = 4'd0;
    pred_q.delete();
    red_q.delete();
  endtask

  // Drives one cycle of stimulus, pushes the expected outputs, returns #1 after the edge.
  task automatic step(input stim_t s);
    logic [3:0] i;
    logic       h;
    logic       mis;
    @(negedge clk);
    if (s.pr) begin
      i = s.ppc[5:2];
      h = m_valid[i] && (m_tag[i] == s.ppc[31:6]);
      m_take = h && m_ctr[i][1];
      m_next = m_take ? m_tgt[i] : s.ppc + 32'd4;
    end
    pred_q.push_back({s.pr, m_take, m_next});
    mis = s.uv && ((s.upt != s.ut) || (s.ut && (s.upnpc != s.utgt)));
    if (mis) begin
      m_rpc = s.ut ? s.utgt : s.upc + 32'd4;
      if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
    end
    red_q.push_back({mis, m_rpc, m_cnt});
    if (s.fl) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
    end else if (s.uv) begin
      i = s.upc[5:2];
      h = m_valid[i] && (m_tag[i] == s.upc[31:6]);
      if (h && s.ut) begin
        m_tgt[i] = s.utgt;
        m_ctr[i] = (m_ctr[i] == 2'b11) ? 2'b11 : m_ctr[i] + 2'd1;
      end else if (h) begin
        m_ctr[i] = (m_ctr[i] == 2'b00) ? 2'b00 : m_ctr[i] - 2'd1;
      end else if (s.ut) begin
        m_valid[i] = 1'b1; m_tag[i] = s.upc[31:6]; m_tgt[i] = s.utgt; m_ctr[i] = 2'b10;
      end
    end
    pred_req = s.pr; pred_pc = s.ppc;
    upd_valid = s.uv; upd_pc = s.upc; upd_taken = s.ut; upd_target = s.utgt;
    upd_pred_take = s.upt; upd_pred_next_pc = s.upnpc; flush_tbl = s.fl;
    @(posedge clk);
    #1;
    pred_req = 1'b0; upd_valid = 1'b0; flush_tbl = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({pred_resp_valid, pred_take, pred_next_pc, redirect_valid, redirect_pc, mispredict_count} !== '0) begin
      n_fails++;
      $display("FAIL reset outputs: got pv=%b pt=%b npc=%h rv=%b rpc=%h cnt=%h, need all 0",
               pred_resp_valid, pred_take, pred_next_pc, redirect_valid, redirect_pc, mispredict_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cold();
    stim_t s [$];
    logic [33:0] pe;
    logic [36:0] re;
    s.push_back(lk(32'h100));
    s.push_back('0);
    foreach (s[j]) begin
      step(s[j]);
      pe = pred_q.pop_front(); re = red_q.pop_front();
      n_checks++;
      if ({pred_resp_valid, pred_take, pred_next_pc} !== pe) begin
        n_fails++;
        $display("FAIL cold pred step %0d: got %h need %h", j, {pred_resp_valid, pred_take, pred_next_pc}, pe);
      end
      n_checks++;
      if ({redirect_valid, redirect_pc, mispredict_count} !== re) begin
        n_fails++;
        $display("FAIL cold redirect step %0d: got %h need %h", j, {redirect_valid, redirect_pc, mispredict_count}, re);
      end
      if (j == 0) begin
        n_checks++;
        if ({pred_resp_valid, pred_take, pred_next_pc} !== {2'b10, 32'h104}) begin
          n_fails++;
          $display("FAIL cold response: got v=%b t=%b npc=%h need 1 0 00000104", pred_resp_valid, pred_take, pred_next_pc);
        end
      end
    end
  endtask

  task automatic test_alloc();
    stim_t s [$];
    logic [33:0] pe;
    logic [36:0] re;
    s.push_back(up(32'h100, 1'b1, 32'h80, 1'b0, 32'h104));
    s.push_back(lk(32'h100));
    foreach (s[j]) begin
      step(s[j]);
      pe = pred_q.pop_front(); re = red_q.pop_front();
      n_checks++;
      if ({pred_resp_valid, pred_take, pred_next_pc} !== pe) begin
        n_fails++;
        $display("FAIL alloc pred step %0d: got %h need %h", j, {pred_resp_valid, pred_take, pred_next_pc}, pe);
      end
      n_checks++;
      if ({redirect_valid, redirect_pc, mispredict_count} !== re) begin
        n_fails++;
        $display("FAIL alloc redirect step %0d: got %h need %h", j, {redirect_valid, redirect_pc, mispredict_count}, re);
      end
      if (j == 0) begin
        n_checks++;
        if ({redirect_valid, redirect_pc, mispredict_count} !== {1'b1, 32'h80, 4'd1}) begin
          n_fails++;
          $display("FAIL alloc redirect: got v=%b pc=%h cnt=%h need 1 00000080 1", redirect_valid, redirect_pc, mispredict_count);
        end
      end
      if (j == 1) begin
        n_checks++;
        if ({pred_take, pred_next_pc} !== {1'b1, 32'h80}) begin
          n_fails++;
          $display("FAIL alloc first use: got t=%b npc=%h need 1 00000080", pred_take, pred_next_pc);
        end
      end
    end
  endtask

  task automatic test_hysteresis();
    stim_t s [$];
    logic [33:0] pe;
    logic [36:0] re;
    s.push_back(up(32'h100, 1'b0, 32'h80, 1'b1, 32'h80));
    s.push_back(lk(32'h100));
    s.push_back(up(32'h100, 1'b0, 32'h80, 1'b0, 32'h104));
    s.push_back(up(32'h100, 1'b0, 32'h80, 1'b0, 32'h104));
    s.push_back(lk(32'h100));
    s.push_back(up(32'h100, 1'b1, 32'h80, 1'b0, 32'h104));
    s.push_back(lk(32'h100));
    s.push_back(up(32'h100, 1'b1, 32'h80, 1'b0, 32'h104));
    s.push_back(lk(32'h100));
    foreach (s[j]) begin
      step(s[j]);
      pe = pred_q.pop_front(); re = red_q.pop_front();
      n_checks++;
      if ({pred_resp_valid, pred_take, pred_next_pc} !== pe) begin
        n_fails++;
        $display("FAIL hysteresis pred step %0d: got %h need %h", j, {pred_resp_valid, pred_take, pred_next_pc}, pe);
      end
      n_checks++;
      if ({redirect_valid, redirect_pc, mispredict_count} !== re) begin
        n_fails++;
        $display("FAIL hysteresis redirect step %0d: got %h need %h", j, {redirect_valid, redirect_pc, mispredict_count}, re);
      end
      if (j == 1 || j == 4 || j == 6 || j == 8) begin
        n_checks++;
        if (pred_take !== (j == 8)) begin
          n_fails++;
          $display("FAIL hysteresis take step %0d: got %b need %b", j, pred_take, (j == 8));
        end
      end
    end
  endtask

  task automatic test_alias();
    stim_t s [$];
    logic [33:0] pe;
    logic [36:0] re;
    s.push_back(lk(32'h140));
    s.push_back(lk(32'h100));
    foreach (s[j]) begin
      step(s[j]);
      pe = pred_q.pop_front(); re = red_q.pop_front();
      n_checks++;
      if ({pred_resp_valid, pred_take, pred_next_pc} !== pe) begin
        n_fails++;
        $display("FAIL alias pred step %0d: got %h need %h", j, {pred_resp_valid, pred_take, pred_next_pc}, pe);
      end
      n_checks++;
      if ({redirect_valid, redirect_pc, mispredict_count} !== re) begin
        n_fails++;
        $display("FAIL alias redirect step %0d: got %h need %h", j, {redirect_valid, redirect_pc, mispredict_count}, re);
      end
      if (j == 0) begin
        n_checks++;
        if ({pred_take, pred_next_pc} !== {1'b0, 32'h144}) begin
          n_fails++;
          $display("FAIL alias lookup: got t=%b npc=%h need 0 00000144", pred_take, pred_next_pc);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    stim_t s [$];
    stim_t both;
    logic [33:0] pe;
    logic [36:0] re;
    both = up(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    both.pr = 1'b1; both.ppc = 32'h100;
    s.push_back(fl());
    s.push_back(both);
    s.push_back(lk(32'h100));
    foreach (s[j]) begin
      step(s[j]);
      pe = pred_q.pop_front(); re = red_q.pop_front();
      n_checks++;
      if ({pred_resp_valid, pred_take, pred_next_pc} !== pe) begin
        n_fails++;
        $display("FAIL same_cycle pred step %0d: got %h need %h", j, {pred_resp_valid, pred_take, pred_next_pc}, pe);
      end
      n_checks++;
      if ({redirect_valid, redirect_pc, mispredict_count} !== re) begin
        n_fails++;
        $display("FAIL same_cycle redirect step %0d: got %h need %h", j, {redirect_valid, redirect_pc, mispredict_count}, re);
      end
      if (j >= 1) begin
        n_checks++;
        if ({pred_take, pred_next_pc} !== ((j == 1) ? {1'b0, 32'h104} : {1'b1, 32'h80})) begin
          n_fails++;
          $display("FAIL same_cycle lookup step %0d: got t=%b npc=%h", j, pred_take, pred_next_pc);
        end
      end
    end
  endtask

  task automatic test_flush();
    stim_t s [$];
    stim_t fu;
    logic [33:0] pe;
    logic [36:0] re;
    fu = up(32'h300, 1'b1, 32'h40, 1'b0, 32'h304);
    fu.fl = 1'b1;
    s.push_back(up(32'h208, 1'b1, 32'h500, 1'b1, 32'h500));
    s.push_back(lk(32'h208));
    s.push_back(fl());
    s.push_back(lk(32'h100));
    s.push_back(lk(32'h208));
    s.push_back(fu);
    s.push_back(lk(32'h300));
    foreach (s[j]) begin
      step(s[j]);
      pe = pred_q.pop_front(); re = red_q.pop_front();
      n_checks++;
      if ({pred_resp_valid, pred_take, pred_next_pc} !== pe) begin
        n_fails++;
        $display("FAIL flush pred step %0d: got %h need %h", j, {pred_resp_valid, pred_take, pred_next_pc}, pe);
      end
      n_checks++;
      if ({redirect_valid, redirect_pc, mispredict_count} !== re) begin
        n_fails++;
        $display("FAIL flush redirect step %0d: got %h need %h", j, {redirect_valid, redirect_pc, mispredict_count}, re);
      end
      if (j == 1 || j == 3 || j == 4 || j == 6) begin
        n_checks++;
        if (pred_take !== (j == 1)) begin
          n_fails++;
          $display("FAIL flush take step %0d: got %b need %b", j, pred_take, (j == 1));
        end
      end
      if (j == 5) begin
        n_checks++;
        if ({redirect_valid, redirect_pc} !== {1'b1, 32'h40}) begin
          n_fails++;
          $display("FAIL flush with update redirect: got v=%b pc=%h need 1 00000040", redirect_valid, redirect_pc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s [$];
    logic [33:0] pe;
    logic [36:0] re;
    for (int k = 0; k < 3; k++) begin
      s.push_back(up(32'h400 + 32'(k * 4), 1'b0, 32'h0, 1'b1, 32'h0));
      s[k].pr = 1'b1;
      s[k].ppc = 32'h700 + 32'(k * 4);
    end
    s.push_back('0);
    foreach (s[j]) begin
      step(s[j]);
      pe = pred_q.pop_front(); re = red_q.pop_front();
      n_checks++;
      if ({pred_resp_valid, pred_take, pred_next_pc} !== pe) begin
        n_fails++;
        $display("FAIL back_to_back pred step %0d: got %h need %h", j, {pred_resp_valid, pred_take, pred_next_pc}, pe);
      end
      n_checks++;
      if ({redirect_valid, redirect_pc, mispredict_count} !== re) begin
        n_fails++;
        $display("FAIL back_to_back redirect step %0d: got %h need %h", j, {redirect_valid, redirect_pc, mispredict_count}, re);
      end
      n_checks++;
      if (redirect_valid !== (j < 3)) begin
        n_fails++;
        $display("FAIL back_to_back pulse step %0d: got %b need %b", j, redirect_valid, (j < 3));
      end
    end
  endtask

  task automatic test_saturation();
    stim_t s [$];
    logic [33:0] pe;
    logic [36:0] re;
    for (int k = 0; k < 20; k++)
      s.push_back(up(32'h200, 1'b0, 32'h0, 1'b1, 32'h0));
    foreach (s[j]) begin
      step(s[j]);
      pe = pred_q.pop_front(); re = red_q.pop_front();
      n_checks++;
      if ({pred_resp_valid, pred_take, pred_next_pc} !== pe) begin
        n_fails++;
        $display("FAIL saturation pred step %0d: got %h need %h", j, {pred_resp_valid, pred_take, pred_next_pc}, pe);
      end
      n_checks++;
      if ({redirect_valid, redirect_pc, mispredict_count} !== re) begin
        n_fails++;
        $display("FAIL saturation redirect step %0d: got %h need %h", j, {redirect_valid, redirect_pc, mispredict_count}, re);
      end
    end
    n_checks++;
    if (mispredict_count !== 4'hF) begin
      n_fails++;
      $display("FAIL saturation count: got %h need f", mispredict_count);
    end
  endtask

  task automatic test_wrap();
    stim_t s [$];
    logic [33:0] pe;
    logic [36:0] re;
    s.push_back(lk(32'hFFFF_FFFC));
    s.push_back(lk(32'h0000_0102));
    foreach (s[j]) begin
      step(s[j]);
      pe = pred_q.pop_front(); re = red_q.pop_front();
      n_checks++;
      if ({pred_resp_valid, pred_take, pred_next_pc} !== pe) begin
        n_fails++;
        $display("FAIL wrap pred step %0d: got %h need %h", j, {pred_resp_valid, pred_take, pred_next_pc}, pe);
      end
      n_checks++;
      if ({redirect_valid, redirect_pc, mispredict_count} !== re) begin
        n_fails++;
        $display("FAIL wrap redirect step %0d: got %h need %h", j, {redirect_valid, redirect_pc, mispredict_count}, re);
      end
      if (j == 0) begin
        n_checks++;
        if (pred_next_pc !== 32'h0) begin
          n_fails++;
          $display("FAIL wrap next pc: got %h need 00000000", pred_next_pc);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t s [$];
    logic [33:0] pe;
    logic [36:0] re;
    @(negedge clk);
    pred_req = 1'b1; pred_pc = 32'h208;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h80;
    upd_pred_take = 1'b0; upd_pred_next_pc = 32'h104;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({pred_resp_valid, pred_take, pred_next_pc, redirect_valid, redirect_pc, mispredict_count} !== '0) begin
      n_fails++;
      $display("FAIL reset_mid async clear: got pv=%b pt=%b npc=%h rv=%b rpc=%h cnt=%h, need all 0",
               pred_resp_valid, pred_take, pred_next_pc, redirect_valid, redirect_pc, mispredict_count);
    end
    @(posedge clk);
    #1;
    pred_req = 1'b0; upd_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    s.push_back('0);
    s.push_back(lk(32'h100));
    foreach (s[j]) begin
      step(s[j]);
      pe = pred_q.pop_front(); re = red_q.pop_front();
      n_checks++;
      if ({pred_resp_valid, pred_take, pred_next_pc} !== pe) begin
        n_fails++;
        $display("FAIL reset_mid pred step %0d: got %h need %h", j, {pred_resp_valid, pred_take, pred_next_pc}, pe);
      end
      n_checks++;
      if ({redirect_valid, redirect_pc, mispredict_count} !== re) begin
        n_fails++;
        $display("FAIL reset_mid redirect step %0d: got %h need %h", j, {redirect_valid, redirect_pc, mispredict_count}, re);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold();
    test_alloc();
    test_hysteresis();
    test_alias();
    test_same_cycle();
    test_flush();
    test_back_to_back();
    test_saturation();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
